// File: rtl/a2d_rr_intf.sv
// SPI master for an ADC128S-style 8-channel 12-bit A2D, cycling round-robin over the
// six IR sensor channels; each request runs an address frame, a gap, then a data frame.
module a2d_rr_intf #(
    parameter int SCLK_DIV = 32,
    parameter int GAP_CLKS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic        rr_clr,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] res,
    output logic        cnv_cmplt,
    output logic [2:0]  chnnl,
    output logic        busy
);

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int GAP_W = $clog2(GAP_CLKS) + 1;
    localparam logic [DIV_W-1:0] DIV_HALF      = DIV_W'(SCLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_PORCH_END = DIV_W'(SCLK_DIV / 2 - 1);
    localparam logic [GAP_W-1:0] GAP_LAST      = GAP_W'(GAP_CLKS - 1);

    typedef enum logic [2:0] {IDLE, FRAME1, GAP, FRAME2, DONE} state_t;

    state_t           state, nxt_state;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [2:0]       rr_idx;
    logic [15:0]      cmd;
    logic [15:0]      shift;

    logic       in_frame, accept, frame_start, frame_end, gap_end;
    logic       porch_start, sclk_rise, sclk_fall, sclk_nxt;
    logic [3:0] mosi_sel;

    always_comb begin
        case (rr_idx)
            3'd0:    chnnl = 3'd1;
            3'd1:    chnnl = 3'd0;
            3'd2:    chnnl = 3'd4;
            3'd3:    chnnl = 3'd2;
            3'd4:    chnnl = 3'd3;
            3'd5:    chnnl = 3'd7;
            default: chnnl = 3'd1;
        endcase
    end

    // The divider starts in the high half, so its MSB inverted is SCLK and the first
    // half period is the front porch; bit_cnt steps at the end of every low/high pair.
    assign in_frame    = (state == FRAME1) || (state == FRAME2);
    assign accept      = (state == IDLE) && strt_cnv;
    assign gap_end     = (state == GAP) && (gap_cnt == GAP_LAST);
    assign frame_end   = in_frame && (bit_cnt == 5'd16) && (div_cnt == DIV_PORCH_END);
    assign porch_start = in_frame && (div_cnt == '0) && (bit_cnt == 5'd0);
    assign sclk_rise   = in_frame && (div_cnt == '0) && (bit_cnt != 5'd0);
    assign sclk_fall   = in_frame && (div_cnt == DIV_HALF) && (bit_cnt < 5'd16);
    assign sclk_nxt    = in_frame ? ~div_cnt[DIV_W-1] : 1'b1;
    assign mosi_sel    = 4'd15 - bit_cnt[3:0];

    always_comb begin
        nxt_state   = state;
        frame_start = 1'b0;
        case (state)
            IDLE: begin
                if (strt_cnv) begin
                    nxt_state   = FRAME1;
                    frame_start = 1'b1;
                end
            end
            FRAME1: if (frame_end) nxt_state = GAP;
            GAP: begin
                if (gap_end) begin
                    nxt_state   = FRAME2;
                    frame_start = 1'b1;
                end
            end
            FRAME2:  if (frame_end) nxt_state = DONE;
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_cnt <= 5'd0;
            gap_cnt <= '0;
        end else begin
            if (frame_start) begin
                div_cnt <= '0;
                bit_cnt <= 5'd0;
            end else if (in_frame) begin
                div_cnt <= div_cnt + 1'b1;
                if (&div_cnt) bit_cnt <= bit_cnt + 5'd1;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

    // Outputs are registered one clk behind the state so SS_n and SCLK move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n      <= 1'b1;
            SCLK      <= 1'b1;
            MOSI      <= 1'b0;
            res       <= 12'h000;
            cnv_cmplt <= 1'b0;
            busy      <= 1'b0;
            rr_idx    <= 3'd0;
        end else begin
            SS_n <= ~in_frame;
            SCLK <= sclk_nxt;
            if (porch_start)    MOSI <= cmd[15];
            else if (sclk_fall) MOSI <= cmd[mosi_sel];
            else if (!in_frame) MOSI <= 1'b0;

            if (accept) begin
                cnv_cmplt <= 1'b0;
                busy      <= 1'b1;
            end else if (state == DONE) begin
                cnv_cmplt <= 1'b1;
                busy      <= 1'b0;
                res       <= shift[11:0];
            end

            if (rr_clr)             rr_idx <= 3'd0;
            else if (state == DONE) rr_idx <= (rr_idx == 3'd5) ? 3'd0 : rr_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)    cmd   <= {2'b00, chnnl, 11'h000};
        if (sclk_rise) shift <= {shift[14:0], MISO};
    end

endmodule

// File: tb/tb_a2d_rr_intf.sv
// Bench for a2d_rr_intf: behavioural A2D slave, MOSI frame capture, and a scoreboard of
// expected channel/result pairs checked when each conversion completes.
module tb_a2d_rr_intf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_cnv = 1'b0;
    logic        rr_clr = 1'b0;
    logic        MISO = 1'b0;
    logic        SS_n, SCLK, MOSI, cnv_cmplt, busy;
    logic [11:0] res;
    logic [2:0]  chnnl;

    a2d_rr_intf #(.SCLK_DIV(32), .GAP_CLKS(32)) dut (
        .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv), .rr_clr(rr_clr), .MISO(MISO),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .res(res), .cnv_cmplt(cnv_cmplt),
        .chnnl(chnnl), .busy(busy)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [2:0]  chan;
        logic [11:0] val;
    } exp_t;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t exp_q[$];
    logic [15:0] mosi_q[$];
    int   nbits_q[$];
    int   chan_map[6] = '{1, 0, 4, 2, 3, 7};
    int   exp_idx = 0;

    logic [15:0] mosi_sh = 16'h0;
    int          mosi_n = 0;
    logic [2:0]  last_chan = 3'd0;
    logic        use_fixed = 1'b0;
    logic [11:0] fixed_val = 12'h000;
    logic [15:0] miso_word = 16'h0;
    int          mbit = 15;
    int          glitch_cnt = 0;

    // A2D slave: returns data for the address received in the previous frame.
    always @(negedge SS_n) begin
        mosi_n    = 0;
        mosi_sh   = 16'h0;
        mbit      = 15;
        miso_word = {4'h0, use_fixed ? fixed_val : ({9'd0, last_chan} * 12'h111)};
    end

    always @(posedge SS_n) begin
        if (rst_n === 1'b1) begin
            mosi_q.push_back(mosi_sh);
            nbits_q.push_back(mosi_n);
            last_chan = mosi_sh[13:11];
        end
    end

    always @(negedge SCLK) begin
        if (SS_n === 1'b0 && mbit >= 0) begin
            MISO = miso_word[mbit];
            mbit = mbit - 1;
        end
    end

    always @(posedge SCLK) begin
        if (SS_n === 1'b0) begin
            mosi_sh = {mosi_sh[14:0], MOSI};
            mosi_n  = mosi_n + 1;
        end
    end

    always @(SCLK) begin
        if (SS_n === 1'b1 && rst_n === 1'b1) glitch_cnt = glitch_cnt + 1;
    end

    task automatic apply_reset();
        rst_n = 1'b0; strt_cnv = 1'b0; rr_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_idx = 0;
        exp_q.delete();
        mosi_q.delete();
        nbits_q.delete();
    endtask

    task automatic pulse_strt();
        @(negedge clk);
        strt_cnv = 1'b1;
        @(posedge clk);
        #1 strt_cnv = 1'b0;
    endtask

    task automatic wait_cmplt(input int limit, output int lat);
        lat = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (cnv_cmplt === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.chan = 3'(chan_map[exp_idx]);
        e.val  = use_fixed ? fixed_val : ({9'd0, e.chan} * 12'h111);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        apply_reset();
        repeat (100) @(negedge clk);
        total_cnt++; if (SS_n !== 1'b1) $display("FAIL reset_ss_n got=%b exp=1", SS_n); else pass_cnt++;
        total_cnt++; if (SCLK !== 1'b1) $display("FAIL reset_sclk got=%b exp=1", SCLK); else pass_cnt++;
        total_cnt++; if (MOSI !== 1'b0) $display("FAIL reset_mosi got=%b exp=0", MOSI); else pass_cnt++;
        total_cnt++; if (cnv_cmplt !== 1'b0) $display("FAIL reset_cmplt got=%b exp=0", cnv_cmplt); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (chnnl !== 3'd1) $display("FAIL reset_chnnl got=%0d exp=1", chnnl); else pass_cnt++;
        total_cnt++; if (res !== 12'h000) $display("FAIL reset_res got=%h exp=000", res); else pass_cnt++;
    endtask

    task automatic test_single();
        logic ss_rec[0:1090];
        logic cm_rec[0:1090];
        logic bz_rec[0:1090];
        int   pts[8]  = '{0, 1, 528, 529, 560, 561, 1088, 1089};
        logic ssv[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int   low_cnt = 0;
        exp_t e;
        use_fixed = 1'b1;
        fixed_val = 12'hABC;
        mosi_q.delete(); nbits_q.delete();
        push_exp();
        pulse_strt();
        for (int k = 0; k <= 1090; k++) begin
            @(negedge clk);
            ss_rec[k] = SS_n; cm_rec[k] = cnv_cmplt; bz_rec[k] = busy;
            if (SS_n === 1'b0) low_cnt++;
        end
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (ss_rec[pts[i]] !== ssv[i]) $display("FAIL single_ss_n T+%0d got=%b exp=%b", pts[i], ss_rec[pts[i]], ssv[i]);
            else pass_cnt++;
        end
        total_cnt++; if (low_cnt != 1056) $display("FAIL single_ss_low_clks got=%0d exp=1056", low_cnt); else pass_cnt++;
        total_cnt++; if (cm_rec[1088] !== 1'b0) $display("FAIL single_cmplt_early got=%b exp=0", cm_rec[1088]); else pass_cnt++;
        total_cnt++; if (cm_rec[1089] !== 1'b1) $display("FAIL single_cmplt got=%b exp=1", cm_rec[1089]); else pass_cnt++;
        total_cnt++; if (bz_rec[0] !== 1'b1 || bz_rec[1088] !== 1'b1) $display("FAIL single_busy_hi got=%b%b exp=11", bz_rec[0], bz_rec[1088]); else pass_cnt++;
        total_cnt++; if (bz_rec[1089] !== 1'b0) $display("FAIL single_busy_lo got=%b exp=0", bz_rec[1089]); else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++; if (res !== e.val) $display("FAIL single_res got=%h exp=%h", res, e.val); else pass_cnt++;
        total_cnt++;
        if (mosi_q.size() != 2 || mosi_q[0] !== 16'h0800 || mosi_q[1] !== 16'h0800 || nbits_q[0] != 16 || nbits_q[1] != 16)
            $display("FAIL single_mosi frames=%0d f0=%h f1=%h exp=2 frames of 0800", mosi_q.size(), mosi_q[0], mosi_q[1]);
        else pass_cnt++;
        exp_idx = (exp_idx + 1) % 6;
        total_cnt++; if (chnnl !== 3'(chan_map[exp_idx])) $display("FAIL single_chnnl_next got=%0d exp=%0d", chnnl, chan_map[exp_idx]); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int   lat;
        exp_t e;
        apply_reset();
        use_fixed = 1'b0;
        for (int i = 0; i < 7; i++) begin
            total_cnt++; if (chnnl !== 3'(chan_map[exp_idx])) $display("FAIL b2b_chnnl[%0d] got=%0d exp=%0d", i, chnnl, chan_map[exp_idx]); else pass_cnt++;
            push_exp();
            mosi_q.delete(); nbits_q.delete();
            pulse_strt();
            wait_cmplt(1200, lat);
            total_cnt++; if (lat != 1089) $display("FAIL b2b_latency[%0d] got=%0d exp=1089", i, lat); else pass_cnt++;
            e = exp_q.pop_front();
            total_cnt++; if (res !== e.val) $display("FAIL b2b_res[%0d] got=%h exp=%h", i, res, e.val); else pass_cnt++;
            total_cnt++;
            if (mosi_q.size() != 2 || mosi_q[1] !== {2'b00, e.chan, 11'h000})
                $display("FAIL b2b_cmd[%0d] frames=%0d got=%h exp=%h", i, mosi_q.size(), mosi_q[1], {2'b00, e.chan, 11'h000});
            else pass_cnt++;
            exp_idx = (exp_idx + 1) % 6;
        end
        total_cnt++; if (chnnl !== 3'(chan_map[exp_idx])) $display("FAIL b2b_wrap got=%0d exp=%0d", chnnl, chan_map[exp_idx]); else pass_cnt++;
    endtask

    task automatic test_ignore();
        int   ncmp = 0;
        int   first = -1;
        int   ss_low_after = 0;
        int   lat;
        logic prev = 1'b0;
        exp_t e;
        use_fixed = 1'b0;
        push_exp();
        mosi_q.delete(); nbits_q.delete();
        pulse_strt();
        for (int k = 0; k < 2300; k++) begin
            @(negedge clk);
            if (k == 9 || k == 599) strt_cnv = 1'b1;
            if (k == 10 || k == 600) strt_cnv = 1'b0;
            if (cnv_cmplt === 1'b1 && prev === 1'b0) begin
                ncmp++;
                if (first < 0) first = k;
            end
            prev = cnv_cmplt;
            if (k > 1089 && SS_n === 1'b0) ss_low_after++;
        end
        total_cnt++; if (ncmp != 1) $display("FAIL ignore_completions got=%0d exp=1", ncmp); else pass_cnt++;
        total_cnt++; if (first != 1089) $display("FAIL ignore_latency got=%0d exp=1089", first); else pass_cnt++;
        total_cnt++; if (ss_low_after != 0 || mosi_q.size() != 2) $display("FAIL ignore_extra_frames low=%0d frames=%0d exp=0/2", ss_low_after, mosi_q.size()); else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++; if (res !== e.val) $display("FAIL ignore_res got=%h exp=%h", res, e.val); else pass_cnt++;
        total_cnt++; if (cnv_cmplt !== 1'b1) $display("FAIL ignore_cmplt_held got=%b exp=1", cnv_cmplt); else pass_cnt++;
        exp_idx = (exp_idx + 1) % 6;
        push_exp();
        pulse_strt();
        @(negedge clk);
        total_cnt++; if (cnv_cmplt !== 1'b0 || busy !== 1'b1) $display("FAIL ignore_cmplt_clear cmplt=%b busy=%b exp=0/1", cnv_cmplt, busy); else pass_cnt++;
        wait_cmplt(1200, lat);
        total_cnt++; if (lat != 1088) $display("FAIL ignore_second_latency got=%0d exp=1088", lat); else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++; if (res !== e.val) $display("FAIL ignore_second_res got=%h exp=%h", res, e.val); else pass_cnt++;
        exp_idx = (exp_idx + 1) % 6;
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic ss_before = 1'b1;
        exp_t e;
        use_fixed = 1'b0;
        mosi_q.delete(); nbits_q.delete();
        pulse_strt();
        for (int k = 0; k < 310; k++) begin
            @(negedge clk);
            ss_before = SS_n;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++; if (ss_before !== 1'b0) $display("FAIL midrst_was_active got=%b exp=0", ss_before); else pass_cnt++;
        total_cnt++; if (SS_n !== 1'b1 || SCLK !== 1'b1) $display("FAIL midrst_ss_sclk got=%b%b exp=11", SS_n, SCLK); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || cnv_cmplt !== 1'b0) $display("FAIL midrst_busy_cmplt got=%b%b exp=00", busy, cnv_cmplt); else pass_cnt++;
        total_cnt++; if (MOSI !== 1'b0 || res !== 12'h000) $display("FAIL midrst_mosi_res mosi=%b res=%h exp=0/000", MOSI, res); else pass_cnt++;
        total_cnt++; if (chnnl !== 3'd1) $display("FAIL midrst_chnnl got=%0d exp=1", chnnl); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_idx = 0;
        exp_q.delete(); mosi_q.delete(); nbits_q.delete();
        push_exp();
        pulse_strt();
        wait_cmplt(1200, lat);
        e = exp_q.pop_front();
        total_cnt++; if (lat != 1089 || res !== e.val) $display("FAIL midrst_next_conv lat=%0d res=%h exp=1089/%h", lat, res, e.val); else pass_cnt++;
        total_cnt++; if (mosi_q.size() != 2 || mosi_q[0] !== 16'h0800) $display("FAIL midrst_next_cmd frames=%0d got=%h exp=0800", mosi_q.size(), mosi_q[0]); else pass_cnt++;
        exp_idx = (exp_idx + 1) % 6;
    endtask

    task automatic test_rr_clr();
        int   lat;
        exp_t e;
        use_fixed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_exp();
            pulse_strt();
            wait_cmplt(1200, lat);
            e = exp_q.pop_front();
            total_cnt++; if (lat != 1089 || res !== e.val) $display("FAIL rrclr_pre[%0d] lat=%0d res=%h exp=1089/%h", i, lat, res, e.val); else pass_cnt++;
            exp_idx = (exp_idx + 1) % 6;
        end
        @(negedge clk); rr_clr = 1'b1;
        @(negedge clk); rr_clr = 1'b0;
        exp_idx = 0;
        total_cnt++; if (chnnl !== 3'd1) $display("FAIL rrclr_chnnl got=%0d exp=1", chnnl); else pass_cnt++;
        mosi_q.delete(); nbits_q.delete();
        push_exp();
        pulse_strt();
        wait_cmplt(1200, lat);
        e = exp_q.pop_front();
        total_cnt++; if (res !== e.val) $display("FAIL rrclr_res got=%h exp=%h", res, e.val); else pass_cnt++;
        total_cnt++; if (mosi_q.size() != 2 || mosi_q[1] !== 16'h0800) $display("FAIL rrclr_cmd frames=%0d got=%h exp=0800", mosi_q.size(), mosi_q[1]); else pass_cnt++;
        exp_idx = (exp_idx + 1) % 6;
        push_exp();
        pulse_strt();
        for (int k = 0; k <= 1089; k++) begin
            @(negedge clk);
            if (k == 1088) begin
                total_cnt++; if (cnv_cmplt !== 1'b0) $display("FAIL rrclr_done_early got=%b exp=0", cnv_cmplt); else pass_cnt++;
                rr_clr = 1'b1;
            end
            if (k == 1089) rr_clr = 1'b0;
        end
        e = exp_q.pop_front();
        exp_idx = 0;
        total_cnt++; if (cnv_cmplt !== 1'b1 || res !== e.val) $display("FAIL rrclr_done cmplt=%b res=%h exp=1/%h", cnv_cmplt, res, e.val); else pass_cnt++;
        total_cnt++; if (chnnl !== 3'd1) $display("FAIL rrclr_coincident_chnnl got=%0d exp=1", chnnl); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_rr_clr();
        total_cnt++; if (glitch_cnt != 0) $display("FAIL sclk_idle_toggle got=%0d exp=0", glitch_cnt); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog_timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
